imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 112 +++++++++++
 tb/tb_imem_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory port A from a byte stream,
// packing big-endian words and holding the CPU in reset until done.
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [31:0]       dina,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [7:0]        checksum
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] FULL_LEN =
    CNT_W'(1 << ADDR_W);

  logic [1:0]        state;
  logic [1:0]        byte_cnt;
  logic [31:0]       shreg;
  logic [CNT_W-1:0]  len_q;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  wcnt_q;
  logic [7:0]        csum_q;

  logic st_idle;
  logic st_load;
  logic st_write;
  logic st_done;
  logic last_word;

  assign st_idle  = (state == S_IDLE);
  assign st_load  = (state == S_LOAD);
  assign st_write = (state == S_WRITE);
  assign st_done  = (state == S_DONE);

  assign last_word =
    ((wcnt_q + CNT_W'(1)) == len_q);

  // All handshake/strobe outputs come from registered state only.
  assign byte_ready = st_load;
  assign wea        = st_write;
  assign busy       = st_load | st_write;
  assign done       = st_done;
  assign cpu_rst    = ~st_done;
  assign addra      = addr_q;
  assign dina       = shreg;
  assign word_cnt   = wcnt_q;
  assign checksum   = csum_q;

  // Load FSM with byte assembly, counters and write address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_cnt <= 2'd0;
      shreg    <= 32'd0;
      len_q    <= '0;
      idx      <= '0;
      addr_q   <= '0;
      wcnt_q   <= '0;
      csum_q   <= 8'd0;
    end else begin
      unique case (1'b1)
        st_idle, st_done: begin
          if (start) begin
            len_q    <= (len == '0) ? FULL_LEN : len;
            wcnt_q   <= '0;
            csum_q   <= 8'd0;
            byte_cnt <= 2'd0;
            idx      <= '0;
            state    <= S_LOAD;
          end
        end
        st_load: begin
          if (byte_valid) begin
            shreg    <= {shreg[23:0], byte_data};
            csum_q   <= csum_q + byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              addr_q <= idx;
              state  <= S_WRITE;
            end
          end
        end
        st_write: begin
          wcnt_q <= wcnt_q + CNT_W'(1);
          idx    <= idx + ADDR_W'(1);
          state  <= last_word ? S_DONE : S_LOAD;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader
// with a word-list reference model and a decoupled write monitor.
module tb_imem_loader;

  localparam int ADDR_W = 6;
  localparam int CNT_W  = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [31:0]       dina;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  word_cnt;
  logic [7:0]        checksum;

  imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wea(wea), .addra(addra),
    .dina(dina), .cpu_rst(cpu_rst), .busy(busy),
    .done(done), .word_cnt(word_cnt), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t         sb[$];
  logic [7:0]  bq[$];
  int          vectors = 0;
  int          errors  = 0;
  longint      cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected word.
  always @(negedge clk) begin
    wr_t e;
    if (wea === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_write: got addra=%h dina=%h expected none",
                 addra, dina);
      end else begin
        e = sb.pop_front();
        chk("addra", 32'(addra), 32'(e.a));
        chk("dina", dina, e.d);
        chk("ready_in_write", 32'(byte_ready), 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int t;
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    do begin
      acc = byte_ready;
      @(posedge clk);
      @(negedge clk);
      t++;
    end while (!acc && t < 100);
    if (!acc) begin
      vectors++;
      errors++;
      $display("FAIL byte_timeout: got no accept expected accept");
    end
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic push_word(input int i);
    wr_t e;
    e.a = ADDR_W'(i / 4);
    e.d = {bq[i-3], bq[i-2], bq[i-1], bq[i]};
    sb.push_back(e);
  endtask

  task automatic do_load(input int lenv, input int gapmax,
                         input int spur, input bit tp);
    int nw;
    int t;
    int g;
    logic [7:0] sum;
    longint c0;
    nw  = (lenv == 0) ? 64 : lenv;
    sum = 8'd0;
    len = CNT_W'(lenv);
    start = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    c0 = cyc;
    start = 1'b0;
    chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_word_cnt", 32'(word_cnt), 32'd0);
    chk("start_checksum", 32'(checksum), 32'd0);
    for (int i = 0; i < 4 * nw; i++) begin
      if (i == spur) begin
        start = 1'b1;
        len = CNT_W'(7);
        @(negedge clk);
        start = 1'b0;
      end
      if (i % 4 == 3) push_word(i);
      sum += bq[i];
      g = (gapmax > 0) ? $urandom_range(gapmax, 1) : 0;
      send_byte(bq[i], g);
    end
    t = 0;
    while (done !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (tp) chk("cycles", 32'(cyc - c0), 32'(5 * nw));
    chk("done", 32'(done), 32'd1);
    chk("done_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_ready", 32'(byte_ready), 32'd0);
    chk("done_wea", 32'(wea), 32'd0);
    chk("word_cnt", 32'(word_cnt), 32'(nw));
    chk("checksum", 32'(checksum), 32'(sum));
    chk("done_addra", 32'(addra), 32'((nw - 1) % 64));
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic rand_bytes(input int n);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l;
    int gm;
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    byte_valid = 1'b0;
    byte_data = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_wea", 32'(wea), 32'd0);
    chk("rst_addra", 32'(addra), 32'd0);
    chk("rst_dina", dina, 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    bq = '{8'h20, 8'h08, 8'h00, 8'h05,
           8'h8C, 8'h01, 8'h00, 8'h00};
    do_load(2, 0, -1, 1'b1);
    chk("checksum_ba", 32'(checksum), 32'hBA);
    do_load(2, 3, -1, 1'b0);

    bq.delete();
    for (int i = 0; i < 256; i++) bq.push_back(8'h01);
    do_load(0, 0, -1, 1'b1);

    rand_bytes(12);
    len = CNT_W'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) push_word(i);
      send_byte(bq[i], 0);
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_wea", 32'(wea), 32'd0);
    chk("mid_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_word_cnt", 32'(word_cnt), 32'd0);
    chk("mid_sb", 32'(sb.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_load(1, 0, -1, 1'b1);

    rand_bytes(12);
    do_load(3, 0, 5, 1'b0);
    rand_bytes(4);
    do_load(1, 1, -1, 1'b0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    byte_valid = 1'b1;
    byte_data = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(byte_ready), 32'd0);
    end
    rand_bytes(4);
    do_load(1, 0, -1, 1'b1);

    for (int r = 0; r < 6; r++) begin
      l  = $urandom_range(10, 1);
      gm = $urandom_range(2, 0);
      rand_bytes(4 * l);
      do_load(l, gm, -1, gm == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
